// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch queue between the 1-cycle instruction memory and the
// IF/ID register. It owns the fetch PC and issues word reads only when a FIFO
// slot is guaranteed for the returning word. Instructions are buffered with
// their PCs and handed to decode under a valid/ready handshake. A jump flushes
// everything and redirects fetch.
module instruction_prefetch_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 20
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      JumpEnable,
    input  logic [ADDR_WIDTH-1:0]     JumpAddress,
    output logic                      MemRead,
    output logic [ADDR_WIDTH-1:0]     MemAddress,
    input  logic [DATA_WIDTH-1:0]     MemData,
    output logic [DATA_WIDTH-1:0]     InstrOut,
    output logic [ADDR_WIDTH-1:0]     InstrPC,
    output logic                      InstrValid,
    input  logic                      InstrReady,
    output logic [$clog2(DEPTH):0]    Occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_mem_read;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic                    r_inflight;
    logic [ADDR_WIDTH-1:0]   r_tag_pc;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [OCC_W-1:0]        r_count;
    logic [DATA_WIDTH-1:0]   r_fifo_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_fifo_pc    [DEPTH];
    logic [OCC_W:0]          w_pending;
    logic                    w_push;
    logic                    w_pop;

    // Slots already promised: buffered entries plus the read still in flight.
    assign w_pending = {1'b0, r_count} + {{OCC_W{1'b0}}, r_inflight};
    // A jump squashes the returning word and any pop in the same cycle.
    assign w_push    = r_inflight & ~JumpEnable;
    assign w_pop     = (r_count != '0) & InstrReady & ~JumpEnable;

    // State register: BOOT for exactly one cycle after reset, then RUN.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and issue decision; reads are issued only with a free credit.
    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        case (r_state)
            BOOT: w_next_state = RUN;
            RUN: begin
                w_next_state = RUN;
                if (!JumpEnable && (w_pending < DEPTH_L)) begin
                    w_mem_read = 1'b1;
                end
            end
            default: w_next_state = BOOT;
        endcase
    end

    // Fetch PC, in-flight flag and FIFO bookkeeping; a jump overrides all.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_pc       <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (JumpEnable) begin
            r_pc       <= JumpAddress;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_mem_read) begin
                r_pc <= r_pc + ADDR_WIDTH'(1);
            end
            r_inflight <= w_mem_read;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Datapath storage: PC tag of the outstanding read and the FIFO payload.
    always_ff @(posedge Clock) begin
        if (w_mem_read) begin
            r_tag_pc <= r_pc;
        end
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= MemData;
            r_fifo_pc[r_wr_ptr]    <= r_tag_pc;
        end
    end

    assign MemRead    = w_mem_read;
    assign MemAddress = r_pc;
    assign InstrValid = (r_count != '0);
    assign InstrOut   = InstrValid ? r_fifo_instr[r_rd_ptr] : '0;
    assign InstrPC    = InstrValid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign Occupancy  = r_count;

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: directed stimulus with a scoreboard
// of expected accepted instructions and direct checks on fetch/occupancy.
module tb_instruction_prefetch_buffer;

    logic        Clock;
    logic        Reset;
    logic        JumpEnable;
    logic [19:0] JumpAddress;
    logic        MemRead;
    logic [19:0] MemAddress;
    logic [19:0] MemData;
    logic [19:0] InstrOut;
    logic [19:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [2:0]  Occupancy;

    typedef struct packed {
        logic [19:0] pc;
        logic [19:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    instruction_prefetch_buffer #(
        .DEPTH(4), .ADDR_WIDTH(20), .DATA_WIDTH(20)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .JumpEnable (JumpEnable),
        .JumpAddress(JumpAddress),
        .MemRead    (MemRead),
        .MemAddress (MemAddress),
        .MemData    (MemData),
        .InstrOut   (InstrOut),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Occupancy  (Occupancy)
    );

    always #5 Clock = ~Clock;

    // Instruction memory: word = address + 0x10000, one cycle after the read.
    always @(posedge Clock) begin
        MemData <= MemRead ? (MemAddress + 20'h10000) : 20'hABCDE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [19:0] pc, input logic [19:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_memread"}, MemRead, 0);
        chk({name, "_memaddr"}, MemAddress, 0);
        chk({name, "_valid"}, InstrValid, 0);
        chk({name, "_instr"}, InstrOut, 0);
        chk({name, "_pc"}, InstrPC, 0);
        chk({name, "_occ"}, Occupancy, 0);
    endtask

    // Monitor: every accepted head is compared with the next expected entry.
    always @(negedge Clock) begin
        if (Reset && InstrValid && InstrReady && !JumpEnable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept: got pc %0h, expected no accept", InstrPC);
            end else begin
                mon_e = exp_q.pop_front();
                chk("accept_pc", InstrPC, mon_e.pc);
                chk("accept_instr", InstrOut, mon_e.instr);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Clock = 0; Reset = 0; JumpEnable = 0; JumpAddress = '0; InstrReady = 0;

        // Reset held with random inputs: every output stays at zero.
        for (int i = 0; i < 3; i++) begin
            JumpEnable  = 1'($urandom_range(0, 1));
            InstrReady  = 1'($urandom_range(0, 1));
            JumpAddress = 20'($urandom);
            @(negedge Clock);
            chk_all_zero("reset_hold");
            tick();
        end

        // Streaming from address 0 with decode always ready.
        JumpEnable = 0; JumpAddress = '0; InstrReady = 1;
        for (int p = 0; p < 8; p++) push_exp(20'(p), 20'(p) + 20'h10000);
        Reset = 1;                                             // cycle 0
        @(negedge Clock); chk("boot_no_issue", MemRead, 0);
        tick(); @(negedge Clock);                              // cycle 1
        chk("first_issue", MemRead, 1); chk("first_addr", MemAddress, 0);
        for (int c = 2; c <= 10; c++) begin
            tick(); @(negedge Clock);
            if (c >= 3) chk("stream_no_bubble", InstrValid, 1);
        end
        tick(); InstrReady = 0; Reset = 0;                     // stop accepting, reset

        // Backpressure from reset.
        tick(); Reset = 1;                                     // cycle 0
        for (int c = 1; c <= 4; c++) begin
            tick(); @(negedge Clock);
            chk("bp_issue", MemRead, 1); chk("bp_addr", MemAddress, 32'(c - 1));
        end
        tick(); @(negedge Clock); chk("bp_stop", MemRead, 0);  // cycle 5
        tick(); @(negedge Clock);                              // cycle 6
        chk("bp_full", Occupancy, 4); chk("bp_hold", MemRead, 0);
        tick();                                                // cycle 7
        tick(); InstrReady = 1; push_exp(20'h00000, 20'h10000); // cycle 8
        tick(); InstrReady = 0; @(negedge Clock);              // cycle 9
        chk("bp_resume", MemRead, 1); chk("bp_resume_addr", MemAddress, 4);
        tick(); @(negedge Clock); chk("bp_one_only", MemRead, 0);   // cycle 10
        tick(); @(negedge Clock); chk("bp_refull", Occupancy, 4);   // cycle 11

        // Pop and jump in the same cycle: pop ignored, FIFO flushed.
        tick(); InstrReady = 1; JumpEnable = 1; JumpAddress = 20'h00200; // cycle 12
        @(negedge Clock); chk("pj_pre_valid", InstrValid, 1);
        tick(); JumpEnable = 0; InstrReady = 0; @(negedge Clock);  // cycle 13
        chk("pj_occ", Occupancy, 0); chk("pj_valid", InstrValid, 0);
        chk("pj_issue", MemRead, 1); chk("pj_addr", MemAddress, 32'h200);
        tick();                                                    // cycle 14
        tick(); InstrReady = 1; push_exp(20'h00200, 20'h10200);    // cycle 15
        @(negedge Clock); chk("pj_head", InstrPC, 32'h200);

        // Jump while a read is in flight: the returning word is dropped.
        tick(); InstrReady = 0; JumpEnable = 1; JumpAddress = 20'h00005; // 16
        tick(); JumpEnable = 0; @(negedge Clock);                  // cycle 17
        chk("if_issue5", MemRead, 1); chk("if_addr5", MemAddress, 5);
        tick(); JumpEnable = 1; JumpAddress = 20'h00100; @(negedge Clock); // 18
        chk("if_jump_noissue", MemRead, 0);
        tick(); JumpEnable = 0; @(negedge Clock);                  // cycle 19
        chk("if_issue100", MemRead, 1); chk("if_addr100", MemAddress, 32'h100);
        chk("if_dropped", Occupancy, 0);
        tick(); @(negedge Clock);                                  // cycle 20
        chk("if_not_yet", InstrValid, 0); chk("if_occ", Occupancy, 0);
        tick(); InstrReady = 1; push_exp(20'h00100, 20'h10100);    // cycle 21
        @(negedge Clock); chk("if_valid_t3", InstrValid, 1); chk("if_pc_t3", InstrPC, 32'h100);

        // PC wrap across the top of the address space.
        tick(); InstrReady = 0; JumpEnable = 1; JumpAddress = 20'hFFFFE; // 22
        tick(); JumpEnable = 0; InstrReady = 1;                    // cycle 23
        push_exp(20'hFFFFE, 20'h0FFFE); push_exp(20'hFFFFF, 20'h0FFFF);
        push_exp(20'h00000, 20'h10000); push_exp(20'h00001, 20'h10001);
        @(negedge Clock); chk("wrap_issue", MemAddress, 32'hFFFFE);
        for (int c = 24; c <= 28; c++) tick();

        // Reset mid-stream: outputs clear at once, fetch restarts at 0.
        tick(); Reset = 0; @(negedge Clock);                       // cycle 29
        chk_all_zero("mid_reset");
        tick();
        tick(); Reset = 1;                                         // cycle 0
        push_exp(20'h00000, 20'h10000); push_exp(20'h00001, 20'h10001);
        @(negedge Clock); chk("rst2_boot", MemRead, 0);
        tick(); @(negedge Clock);                                  // cycle 1
        chk("rst2_issue", MemRead, 1); chk("rst2_addr", MemAddress, 0);
        for (int c = 2; c <= 4; c++) tick();
        tick(); InstrReady = 0;                                    // cycle 5
        for (int c = 0; c < 3; c++) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
